// File: rtl/imm_encoder_pkg.sv
// rtl/imm_encoder_pkg.sv - shared immediate-format and buffer-state encodings
// Purpose: ImmSrc format codes, encoder buffer states and the buffered entry
//          type, shared by the encoder and the decode-stage extender.
// Ports:   none (package).
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_TWO   = 2'b10
  } buf_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } entry_t;

endpackage

// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/response handshake bundle of the immediate encoder
// Purpose: groups the request side (in_*) and the encoded-instruction side
//          (out_*) of the encoder.
// Ports:   master drives requests and out_ready; slave is the encoder.
interface imm_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ImmSrc;
  logic [31:0] imm;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;

  modport master (
    output in_valid, ImmSrc, imm, base_instr, out_ready,
    input  in_ready, out_valid, instr, err
  );

  modport slave (
    input  in_valid, ImmSrc, imm, base_instr, out_ready,
    output in_ready, out_valid, instr, err
  );

endinterface

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational immediate placement and range check
// Purpose: places imm into base_instr according to the format and flags
//          immediates that do not fit, or illegal formats.
// Ports:   imm_src/imm/base_instr in; instr/err out.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [31:0] base_instr,
  output logic [31:0] instr,
  output logic        err
);

  // A field fits when every bit above its top is a copy of the sign bit.
  logic is_ok;
  logic b_ok;
  logic j_ok;
  logic u_ok;

  assign is_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign u_ok  = ~(|imm[11:0]);

  always_comb begin
    instr = base_instr;
    err   = 1'b1;
    case (imm_src)
      IMM_I: begin
        instr[31:20] = imm[11:0];
        err          = ~is_ok;
      end
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        err          = ~is_ok;
      end
      IMM_B: begin
        instr[31]    = imm[12];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        instr[7]     = imm[11];
        err          = ~b_ok;
      end
      IMM_J: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
        err          = ~j_ok;
      end
      IMM_U: begin
        instr[31:12] = imm[31:12];
        err          = ~u_ok;
      end
      default: begin
        instr = base_instr;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - immediate encoder with two-entry output buffer and statistics
// Purpose: encodes one immediate per accepted request, buffers results in a
//          main register plus skid register, counts good and errored outputs.
// Ports:   clk, rst_n (async active-low); bus (slave handshake);
//          enc_cnt/err_cnt saturating counters of transferred outputs.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  buf_state_e state;
  entry_t     main_q;
  entry_t     skid_q;
  entry_t     packed_in;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       in_xfer;
  logic       out_xfer;

  imm_pack u_pack (
    .imm_src    (bus.ImmSrc),
    .imm        (bus.imm),
    .base_instr (bus.base_instr),
    .instr      (packed_in.instr),
    .err        (packed_in.err)
  );

  assign in_xfer       = bus.in_valid & in_ready_q;
  assign out_xfer      = out_valid_q & bus.out_ready;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.instr     = main_q.instr;
  assign bus.err       = main_q.err;

  // in_ready stays low during reset and rises on the first edge after it,
  // so it is a register tracking the next state rather than a decode of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BUF_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            main_q      <= packed_in;
            state       <= BUF_ONE;
            out_valid_q <= 1'b1;
          end
        end
        BUF_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_q     <= packed_in;
            state      <= BUF_TWO;
            in_ready_q <= 1'b0;
          end else if (out_xfer && !in_xfer) begin
            state       <= BUF_EMPTY;
            out_valid_q <= 1'b0;
          end else if (out_xfer && in_xfer) begin
            main_q <= packed_in;
          end
        end
        BUF_TWO: begin
          if (out_xfer) begin
            main_q     <= skid_q;
            state      <= BUF_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= BUF_EMPTY;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (out_xfer) begin
      if (main_q.err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else begin
        if (enc_cnt != '1) enc_cnt <= enc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed self-checking bench for imm_encoder
module tb_imm_encoder;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  imm_encoder_if bus ();

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .enc_cnt (enc_cnt),
    .err_cnt (err_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_enc = 0;
  int exp_err = 0;
  logic [31:0] last_instr;
  logic [31:0] rimm;
  logic [31:0] r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Decode-stage extender: recovers the immediate from an encoded instruction.
  function automatic logic [31:0] extend(input logic [2:0] src, input logic [31:0] i);
    case (src)
      3'd0: return {{20{i[31]}}, i[31:20]};
      3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {i[31:12], 12'h000};
    endcase
  endfunction

  task automatic push(input logic [2:0] src, input logic [31:0] v, input logic [31:0] b);
    bus.ImmSrc = src;
    bus.imm = v;
    bus.base_instr = b;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20 && !bus.in_ready; n++) @(posedge clk) #1;
    check("push_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pop(input logic [31:0] ei, input logic ee, input bit chk_instr, input string tag);
    check({tag, "_latency"}, {31'd0, bus.out_valid}, 32'd1);
    for (int n = 0; n < 20 && !bus.out_valid; n++) @(posedge clk) #1;
    last_instr = bus.instr;
    if (chk_instr) check({tag, "_instr"}, bus.instr, ei);
    check({tag, "_err"}, {31'd0, bus.err}, {31'd0, ee});
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    if (ee) exp_err = sat_inc(exp_err);
    else exp_enc = sat_inc(exp_enc);
    check({tag, "_enc_cnt"}, {30'd0, enc_cnt}, exp_enc);
    check({tag, "_err_cnt"}, {30'd0, err_cnt}, exp_err);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.ImmSrc = 3'd0;
    bus.imm = '0;
    bus.base_instr = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_enc_cnt", {30'd0, enc_cnt}, 32'd0);
    check("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    check("rel_in_ready_pre", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    push(3'd0, 32'hFFFF_F800, 32'h0000_0013);
    pop(32'h8000_0013, 1'b0, 1'b1, "i_neg2048");
    push(3'd2, 32'h0000_0FFE, 32'h0000_0063);
    pop(32'h7E00_0FE3, 1'b0, 1'b1, "b_max");
    push(3'd2, 32'h0000_0003, 32'h0000_0063);
    pop(32'h0000_0163, 1'b1, 1'b1, "b_odd");
    push(3'd7, 32'h0000_0000, 32'h1234_5678);
    pop(32'h1234_5678, 1'b1, 1'b1, "illegal_src");
    push(3'd4, 32'h0000_0001, 32'h0000_0037);
    pop(32'h0000_0037, 1'b1, 1'b1, "u_low_bits");
    push(3'd1, 32'h0000_1000, 32'h0000_0023);
    pop(32'h0000_0023, 1'b1, 1'b1, "s_range");
    push(3'd3, 32'h0010_0000, 32'h0000_006F);
    pop(32'h8000_006F, 1'b1, 1'b1, "j_range");
    push(3'd3, 32'hFFFF_FFFE, 32'h0000_006F);
    pop(32'hFFFF_F06F, 1'b0, 1'b1, "j_neg2");
    push(3'd4, 32'h1234_5000, 32'h0000_0037);
    pop(32'h1234_5037, 1'b0, 1'b1, "u_ok");
    push(3'd1, 32'hFFFF_FFFC, 32'h0011_2023);
    pop(32'hFE11_2E23, 1'b0, 1'b1, "s_neg4");

    for (int k = 0; k < 4; k++) begin
      for (int f = 0; f < 5; f++) begin
        r = $urandom;
        case (f)
          0, 1: rimm = {{20{r[11]}}, r[11:0]};
          2: rimm = {{19{r[12]}}, r[12:1], 1'b0};
          3: rimm = {{11{r[20]}}, r[20:1], 1'b0};
          default: rimm = {r[31:12], 12'h000};
        endcase
        push(f[2:0], rimm, $urandom);
        pop(32'h0, 1'b0, 1'b0, "roundtrip");
        check("roundtrip_imm", extend(f[2:0], last_instr), rimm);
      end
    end

    push(3'd0, 32'h1, 32'h0000_0013);
    push(3'd0, 32'h2, 32'h0000_0013);
    bus.ImmSrc = 3'd0;
    bus.imm = 32'h3;
    bus.base_instr = 32'h0000_0013;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk) #1;
    check("two_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("two_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("two_hold_instr", bus.instr, 32'h0010_0013);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain_second", bus.instr, 32'h0020_0013);
    check("drain_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("drain_third", bus.instr, 32'h0030_0013);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("drain_empty", {31'd0, bus.out_valid}, 32'd0);
    exp_enc = sat_inc(sat_inc(sat_inc(exp_enc)));
    check("drain_enc_cnt", {30'd0, enc_cnt}, exp_enc);

    push(3'd0, 32'h7, 32'h0000_0013);
    push(3'd0, 32'h8, 32'h0000_0013);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("midrst_enc_cnt", {30'd0, enc_cnt}, 32'd0);
    check("midrst_err_cnt", {30'd0, err_cnt}, 32'd0);
    check("midrst_instr", bus.instr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_enc = 0;
    exp_err = 0;
    @(posedge clk);
    #1;
    check("postrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      check("postrst_no_stale", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    push(3'd0, 32'h5, 32'h0000_0013);
    pop(32'h0050_0013, 1'b0, 1'b1, "postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
